// File: rtl/spi_tx_ctrl.sv
// SPI mode-0 transmit controller: sequences an external shift register, Sclk and Cs_n per frame.
// Optional one-entry holding buffer for back-to-back frames when SPI_TX_BUFFER_EN is defined.
module spi_tx_ctrl #(
    parameter int SIZE = 8,
    parameter int DIV  = 2
) (
    input  logic            Clk,
    input  logic            Rst_n,
    input  logic            Start,
    input  logic [SIZE-1:0] DataIn,
    output logic            ShLoad,
    output logic            ShEn,
    output logic [SIZE-1:0] ShData,
    output logic            Sclk,
    output logic            Cs_n,
    output logic            Busy,
    output logic            Done,
    output logic            BufFull,
    output logic            Overrun
);

    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW = $clog2(SIZE + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(SIZE);

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, HOLD, DONE} state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   div_q, div_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic [SIZE-1:0] sh_data_d;
    logic            sh_load_d, sh_en_d, sclk_d, cs_n_d, busy_d, done_d, overrun_d;
    logic            launch, take;
    logic [SIZE-1:0] launch_data;
    logic            buf_rdy;
    logic [SIZE-1:0] buf_val;

`ifdef SPI_TX_BUFFER_EN
    logic            buf_full_q, buf_full_d;
    logic [SIZE-1:0] buf_data_q, buf_data_d;
    assign buf_rdy = buf_full_q;
    assign buf_val = buf_data_q;
    assign BufFull = buf_full_q;
`else
    assign buf_rdy = 1'b0;
    assign buf_val = '0;
    assign BufFull = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        bit_d       = bit_q;
        sh_data_d   = ShData;
        sclk_d      = Sclk;
        cs_n_d      = Cs_n;
        busy_d      = Busy;
        sh_load_d   = 1'b0;
        sh_en_d     = 1'b0;
        done_d      = 1'b0;
        overrun_d   = 1'b0;
        launch      = 1'b0;
        take        = 1'b0;
        launch_data = '0;
`ifdef SPI_TX_BUFFER_EN
        buf_full_d  = buf_full_q;
        buf_data_d  = buf_data_q;
`endif
        unique case (state_q)
            IDLE: begin
                // A frame left in the buffer by a Start during DONE takes priority.
                if (buf_rdy) begin
                    launch      = 1'b1;
                    launch_data = buf_val;
                end else if (Start) begin
                    launch      = 1'b1;
                    launch_data = DataIn;
                    take        = 1'b1;
                end
            end
            LOAD: begin
                state_d = SHIFT;
                div_d   = '0;
                bit_d   = '0;
                sclk_d  = 1'b0;
            end
            SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (Sclk) begin
                        sclk_d  = 1'b0;
                        sh_en_d = (bit_q != BIT_LAST);
                    end else if (bit_q == BIT_LAST) begin
                        state_d = HOLD;
                    end else begin
                        sclk_d = 1'b1;
                        bit_d  = bit_q + BW'(1);
                    end
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            HOLD: begin
                if (div_q == DIV_LAST) begin
                    div_d   = '0;
                    state_d = DONE;
                    cs_n_d  = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            DONE: begin
                if (buf_rdy) begin
                    launch      = 1'b1;
                    launch_data = buf_val;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (launch) begin
            state_d   = LOAD;
            sh_data_d = launch_data;
            sh_load_d = 1'b1;
            busy_d    = 1'b1;
            cs_n_d    = 1'b0;
`ifdef SPI_TX_BUFFER_EN
            if (buf_full_q) buf_full_d = 1'b0;
`endif
        end

        // Any Start not accepted straight from IDLE is a busy-time request.
        if (Start && !take) begin
`ifdef SPI_TX_BUFFER_EN
            if (!buf_full_q) begin
                buf_data_d = DataIn;
                buf_full_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
`else
            overrun_d = 1'b1;
`endif
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            ShData  <= '0;
            ShLoad  <= 1'b0;
            ShEn    <= 1'b0;
            Sclk    <= 1'b0;
            Cs_n    <= 1'b1;
            Busy    <= 1'b0;
            Done    <= 1'b0;
            Overrun <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            ShData  <= sh_data_d;
            ShLoad  <= sh_load_d;
            ShEn    <= sh_en_d;
            Sclk    <= sclk_d;
            Cs_n    <= cs_n_d;
            Busy    <= busy_d;
            Done    <= done_d;
            Overrun <= overrun_d;
        end
    end

`ifdef SPI_TX_BUFFER_EN
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            buf_full_q <= 1'b0;
            buf_data_q <= '0;
        end else begin
            buf_full_q <= buf_full_d;
            buf_data_q <= buf_data_d;
        end
    end
`endif

endmodule

// File: tb/tb_spi_tx_ctrl.sv
// Bench for spi_tx_ctrl: two instances (SIZE=8/DIV=2 and SIZE=2/DIV=1) checked every cycle
// against a frame-offset timing model, plus a hand-derived vector table for the 8'hA5 frame.
module tb_spi_tx_ctrl;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic       Rst_n, Start;
    logic [7:0] din0;
    logic [1:0] din1;

    logic       ld0, en0, sclk0, csn0, busy0, done0, bf0, ovr0;
    logic [7:0] sd0;
    logic       ld1, en1, sclk1, csn1, busy1, done1, bf1, ovr1;
    logic [1:0] sd1;

    spi_tx_ctrl #(.SIZE(8), .DIV(2)) u0 (
        .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .DataIn(din0),
        .ShLoad(ld0), .ShEn(en0), .ShData(sd0), .Sclk(sclk0), .Cs_n(csn0),
        .Busy(busy0), .Done(done0), .BufFull(bf0), .Overrun(ovr0)
    );

    spi_tx_ctrl #(.SIZE(2), .DIV(1)) u1 (
        .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .DataIn(din1),
        .ShLoad(ld1), .ShEn(en1), .ShData(sd1), .Sclk(sclk1), .Cs_n(csn1),
        .Busy(busy1), .Done(done1), .BufFull(bf1), .Overrun(ovr1)
    );

    localparam int NONE = -1000000;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int sz[2]  = '{8, 2};
    int dv[2]  = '{2, 1};

    // Reference model: accept cycle of the current frame, its data, the buffer, the Overrun due.
    int         acc[2];
    logic [7:0] cur[2], bufd[2], sr[2];
    bit         bfull[2], ovr[2];

    typedef struct {
        int         off;
        logic [5:0] v;   // {ShLoad, ShEn, Sclk, Cs_n, Busy, Done}
    } tv_t;
    tv_t tv[11];

    function automatic logic [15:0] get_act(input int id);
        if (id == 0) return {ld0, en0, sclk0, csn0, busy0, done0, bf0, ovr0, sd0};
        return {ld1, en1, sclk1, csn1, busy1, done1, bf1, ovr1, 6'b0, sd1};
    endfunction

    // Frame timeline from the accept cycle A: LOAD at A+1, SHIFT from A+2 for DIV*(2*SIZE+1)
    // cycles (low half, then SIZE full periods), HOLD for DIV cycles, DONE at A+2+2*DIV*(SIZE+1).
    function automatic logic [15:0] get_exp(input int id);
        int   o, L, s, h;
        logic ld, en, sc, cn, bz, dn;
        ld = 0; en = 0; sc = 0; cn = 1; bz = 0; dn = 0;
        L = 2 + 2 * dv[id] * (sz[id] + 1);
        o = cyc - acc[id];
        if (acc[id] != NONE && o >= 1 && o <= L) begin
            cn = 0; bz = 1;
            if (o == 1) begin
                ld = 1;
            end else if (o < 2 + dv[id] * (2 * sz[id] + 1)) begin
                s  = o - 2;
                h  = s / dv[id];
                sc = h[0];
                en = (s % dv[id] == 0) && (h % 2 == 0) && (h >= 2) && (h <= 2 * sz[id] - 2);
            end else if (o == L) begin
                cn = 1; bz = 0; dn = 1;
            end
        end
        return {ld, en, sc, cn, bz, dn, bfull[id], ovr[id], cur[id]};
    endfunction

    task automatic model_edge(input int id, input logic [7:0] data);
        int L, o;
        bit idle, bfo, busy_start;
        if (!Rst_n) begin
            acc[id] = NONE; bfull[id] = 0; ovr[id] = 0; cur[id] = 0; bufd[id] = 0;
            return;
        end
        L          = 2 + 2 * dv[id] * (sz[id] + 1);
        o          = cyc - acc[id];
        idle       = (acc[id] == NONE) || (o > L);
        bfo        = bfull[id];
        ovr[id]    = 0;
        busy_start = Start;
        if (bfo && (idle || o == L)) begin
            acc[id] = cyc; cur[id] = bufd[id]; bfull[id] = 0;
        end else if (idle && Start) begin
            acc[id] = cyc; cur[id] = data; busy_start = 0;
        end
        if (busy_start) begin
`ifdef SPI_TX_BUFFER_EN
            if (!bfo) begin
                bufd[id] = data; bfull[id] = 1;
            end else begin
                ovr[id] = 1;
            end
`else
            ovr[id] = 1;
`endif
        end
    endtask

    task automatic check_all();
        logic [15:0] e, a;
        int o, s, h, k;
        for (int id = 0; id < 2; id++) begin
            e = get_exp(id);
            a = get_act(id);
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL dut%0d outputs cyc %0d: got %b expected %b", id, cyc, a, e);
            end
            // On each expected Sclk rise, MOSI (shift-register MSB) must carry the next data bit.
            o = cyc - acc[id];
            if (acc[id] != NONE && o >= 2 && o < 2 + dv[id] * (2 * sz[id] + 1)) begin
                s = o - 2;
                h = s / dv[id];
                if (s % dv[id] == 0 && h[0]) begin
                    k = (h + 1) / 2;
                    checks++;
                    if (sr[id][sz[id]-1] !== cur[id][sz[id]-k]) begin
                        errors++;
                        $display("FAIL dut%0d mosi bit %0d cyc %0d: got %b expected %b",
                                 id, k, cyc, sr[id][sz[id]-1], cur[id][sz[id]-k]);
                    end
                end
            end
        end
    endtask

    task automatic step();
        if (ld0) sr[0] = sd0; else if (en0) sr[0] = sr[0] << 1;
        if (ld1) sr[1] = {6'b0, sd1}; else if (en1) sr[1] = sr[1] << 1;
        model_edge(0, din0);
        model_edge(1, {6'b0, din1});
        @(posedge Clk);
        cyc++;
        @(negedge Clk);
        check_all();
    endtask

    initial begin
        logic [5:0] got;
        tv[0]  = '{0,  6'b000100};
        tv[1]  = '{1,  6'b100010};
        tv[2]  = '{2,  6'b000010};
        tv[3]  = '{4,  6'b001010};
        tv[4]  = '{6,  6'b010010};
        tv[5]  = '{8,  6'b001010};
        tv[6]  = '{32, 6'b001010};
        tv[7]  = '{34, 6'b000010};
        tv[8]  = '{36, 6'b000010};
        tv[9]  = '{38, 6'b000101};
        tv[10] = '{39, 6'b000100};

        for (int id = 0; id < 2; id++) begin
            acc[id] = NONE; cur[id] = 0; bufd[id] = 0; sr[id] = 0; bfull[id] = 0; ovr[id] = 0;
        end

        // Reset with Start held high: the Start must be discarded.
        Rst_n = 0; Start = 1; din0 = 8'hFF; din1 = 2'b11;
        repeat (3) step();
        Rst_n = 1; Start = 0;
        repeat (2) step();

        // 8'hA5 frame against hand-derived vectors; the small instance sends 2'b10.
        Start = 1; din0 = 8'hA5; din1 = 2'b10;
        for (int off = 0; off <= 40; off++) begin
            got = {ld0, en0, sclk0, csn0, busy0, done0};
            for (int i = 0; i < 11; i++) begin
                if (tv[i].off == off) begin
                    checks++;
                    if (got !== tv[i].v) begin
                        errors++;
                        $display("FAIL table off %0d: got %b expected %b", off, got, tv[i].v);
                    end
                end
            end
            step();
            Start = 0;
        end
        repeat (5) step();

        // Start mid-frame.
        Start = 1; din0 = 8'h5A; din1 = 2'b01;
        step(); Start = 0;
        repeat (10) step();
        Start = 1; din0 = 8'hE7; din1 = 2'b11;
        step(); Start = 0;
        repeat (45) step();

        // Reset after the third Sclk rise, then a clean 8'h3C frame.
        Start = 1; din0 = 8'hC3; din1 = 2'b01;
        step(); Start = 0;
        repeat (13) step();
        Rst_n = 0;
        step();
        Rst_n = 1; Start = 1; din0 = 8'h3C; din1 = 2'b10;
        step(); Start = 0;
        repeat (45) step();

        // Back-to-back requests: second buffered (when enabled), third dropped.
        Start = 1; din0 = 8'h11; din1 = 2'b01;
        step(); Start = 0;
        repeat (8) step();
        Start = 1; din0 = 8'h22; din1 = 2'b10;
        step(); Start = 0;
        repeat (4) step();
        Start = 1; din0 = 8'h33; din1 = 2'b11;
        step(); Start = 0;
        repeat (90) step();

        // Random traffic with occasional resets.
        repeat (4000) begin
            Rst_n = ($urandom_range(0, 299) != 0);
            Start = ($urandom_range(0, 9) == 0);
            din0  = 8'($urandom);
            din1  = 2'($urandom);
            step();
        end
        Rst_n = 1; Start = 0;
        repeat (60) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_tx_ctrl.md
SPI_TX_CTRL -- requirements
Module: spi_tx_ctrl

Interface
REQ-001 Parameter SIZE, default 8: frame width in bits; SHALL be ≥2.
REQ-002 Parameter DIV, default 2: Sclk half-period in Clk cycles; SHALL be ≥1.
REQ-003 Clk  input  1: single clock; all logic SHALL be rising-edge of Clk.
REQ-004 Rst_n  input  1: reset, synchronous and active-low.
REQ-005 Start  input  1: request to transmit DataIn; sampled every Clk.
REQ-006 DataIn  input  SIZE: frame to transmit, captured when Start is accepted.
REQ-007 ShLoad  output  1: parallel-load strobe to the tx shift register.
REQ-008 ShEn  output  1: shift-enable strobe to the tx shift register.
REQ-009 ShData  output  SIZE: parallel data presented to the tx shift register.
REQ-010 Sclk  output  1: SPI serial clock, mode 0 (idle low).
REQ-011 Cs_n  output  1: SPI chip select, active-low.
REQ-012 Busy  output  1: high from accept to end of frame.
REQ-013 Done  output  1: one-cycle pulse at frame completion.
REQ-014 BufFull  output  1: holding buffer occupied (Configuration).
REQ-015 Overrun  output  1: one-cycle pulse when a Start is dropped.

Function
REQ-016 All outputs SHALL be registered; FSM states SHALL be IDLE, LOAD, SHIFT, HOLD, DONE.
REQ-017 IDLE: Start=1 at cycle T SHALL give ShData=DataIn, ShLoad=1, Busy=1, Cs_n=0 at T+1 (state LOAD); Start=0 stays IDLE.
REQ-018 LOAD: ShLoad SHALL be high exactly one cycle; next state SHIFT with divider counter cleared, Sclk=0.
REQ-019 SHIFT: Sclk SHALL toggle every DIV Clk cycles, giving SIZE rising edges per frame, first rising edge DIV cycles after entering SHIFT.
REQ-020 ShEn SHALL pulse for one Clk cycle coincident with each Sclk falling edge except the SIZE-th, i.e. exactly SIZE-1 pulses per frame.
REQ-021 A bit counter SHALL count Sclk rising edges 0..SIZE; after the SIZE-th falling edge FSM SHALL enter HOLD with Sclk=0.
REQ-022 HOLD: Cs_n=0, Sclk=0 for DIV cycles, then DONE.
REQ-023 DONE (one cycle): Cs_n=1, Done=1, Busy=0; next state IDLE, or LOAD per REQ-029.
REQ-024 Start while Busy=1 and not buffered (REQ-029/030) SHALL be ignored and pulse Overrun the next cycle.
REQ-025 ShLoad and ShEn SHALL never be high in the same cycle; Sclk SHALL be 0 whenever Cs_n=1.
REQ-026 Start in the DONE cycle SHALL be treated as Busy (REQ-024/029).

Reset
REQ-027 Rst_n=0 at any rising Clk edge, including mid-frame, SHALL force IDLE, counters 0, buffer empty, ShData=0, ShLoad=0, ShEn=0, Sclk=0, Cs_n=1, Busy=0, Done=0, BufFull=0, Overrun=0.
REQ-028 Start coincident with Rst_n=0 SHALL be discarded.

Configuration
REQ-029 With SPI_TX_BUFFER_EN defined: Start while Busy and BufFull=0 SHALL capture DataIn into a one-entry buffer, BufFull=1 next cycle; at DONE a full buffer SHALL go directly to LOAD (ShData=buffer, BufFull=0), Busy staying low only during the DONE cycle.
REQ-030 With SPI_TX_BUFFER_EN defined: Start while BufFull=1 SHALL be dropped with Overrun pulse; buffer contents unchanged.
REQ-031 Without SPI_TX_BUFFER_EN: no buffer logic; BufFull SHALL be tied 0; all Start while Busy follow REQ-024.

Verification
REQ-032 SIZE=8, DIV=2, Start=1 one cycle, DataIn=8'hA5 -> ShLoad 1 cycle, 8 Sclk periods of 4 Clk, 7 ShEn pulses on falling edges, MOSI via shift register = 1,0,1,0,0,1,0,1, Done 1 cycle, Cs_n=1 after.
REQ-033 Start pulse mid-frame (macro off) -> frame unaffected, Overrun 1 cycle, no second frame.
REQ-034 Rst_n=0 after 3rd Sclk rise -> next edge Cs_n=1, Sclk=0, Busy=0; new Start 8'h3C then transmits full frame.
REQ-035 Macro on: Start 8'h11 then Start 8'h22 mid-frame -> BufFull=1, second frame starts after Done with no IDLE gap; third Start during first frame -> Overrun.
REQ-036 DIV=1, SIZE=2, DataIn=2'b10 -> Sclk toggles every Clk, 1 ShEn pulse, Done 2 Clk after last Sclk fall.
